// File: rtl/pulse_stretch_mc_if.sv
// Port bundle for pulse_stretch_mc: event inputs, length configuration and
// the stretched outputs. The master side drives events and configuration,
// and the slave side is the stretcher itself.
interface pulse_stretch_mc_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
);
   logic [CHANNELS-1:0] pulse_in;
   logic [CNT_W-1:0]    ext_len;
   logic [CNT_W-1:0]    gap_len;
   logic                retrig;
   logic [CHANNELS-1:0] ext_out;
   logic [CHANNELS-1:0] dropped;
   logic                busy;

   modport master (
      output pulse_in, ext_len, gap_len, retrig,
      input  ext_out, dropped, busy
   );

   modport slave (
      input  pulse_in, ext_len, gap_len, retrig,
      output ext_out, dropped, busy
   );
endinterface

// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher. Each channel turns a rising edge on its
// pulse_in bit into an output pulse of max(ext_len,1) cycles, optionally
// followed by a gap_len-cycle blanking interval in which new edges are
// reported on dropped instead of being acted on.
module pulse_stretch_mc #(
   parameter int CHANNELS     = 4,
   parameter int CNT_W        = 16,
   parameter bit NEGATIVE_OUT = 1'b0,
   parameter int SYNC_STAGES  = 0
) (
   input logic               clk,
   input logic               rst,
   pulse_stretch_mc_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic ACT_LVL  = !NEGATIVE_OUT;
   localparam logic IDLE_LVL = NEGATIVE_OUT;
   // The edge detector stays masked until the input path has settled after
   // reset, so a level already high at release is never seen as an edge.
   localparam int   ARM_CYCLES = SYNC_STAGES + 1;

   logic [CHANNELS-1:0] p;
   logic [CHANNELS-1:0] p_d;
   logic [CHANNELS-1:0] rise;
   logic [2:0]          arm_cnt;
   logic                armed;
   logic [CNT_W-1:0]    len_load;
   logic [CNT_W-1:0]    gap_load;

   state_t              state_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_q   [CHANNELS];
   logic [CHANNELS-1:0] ext_q;
   logic [CHANNELS-1:0] drop_q;
   logic                busy_c;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign p = bus.pulse_in;
      end else begin : g_sync
         logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

         // Synchronizer chain for inputs coming from another clock domain.
         // NOTE: sequential state is written with non-blocking assignments so
         // every flop samples the pre-edge value of its neighbours.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            end else begin
               sync_q[0] <= bus.pulse_in;
               for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            end
         end

         assign p = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Edge-detect history and the post-reset arming counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_d     <= '0;
         arm_cnt <= '0;
      end else begin
         p_d <= p;
         if (!armed) arm_cnt <= arm_cnt + 3'd1;
      end
   end

   assign armed = (arm_cnt == 3'(ARM_CYCLES));
   assign rise  = p & ~p_d & {CHANNELS{armed}};

   // Length 0 behaves like 1; counters hold "cycles remaining minus one".
   assign len_load = (bus.ext_len == '0) ? '0 : bus.ext_len - CNT_W'(1);
   assign gap_load = bus.gap_len - CNT_W'(1);

   // Per-channel FSM; ext_out and dropped are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
         ext_q  <= {CHANNELS{IDLE_LVL}};
         drop_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            drop_q[i] <= 1'b0;
            unique case (state_q[i])
               ST_IDLE: begin
                  if (rise[i]) begin
                     state_q[i] <= ST_ON;
                     cnt_q[i]   <= len_load;
                     ext_q[i]   <= ACT_LVL;
                  end else begin
                     ext_q[i] <= IDLE_LVL;
                  end
               end
               ST_ON: begin
                  if (rise[i] && bus.retrig) begin
                     // A retrigger reload wins over the end-of-pulse exit.
                     cnt_q[i] <= len_load;
                     ext_q[i] <= ACT_LVL;
                  end else begin
                     drop_q[i] <= rise[i];
                     if (cnt_q[i] != '0) begin
                        cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                        ext_q[i] <= ACT_LVL;
                     end else if (bus.gap_len != '0) begin
                        state_q[i] <= ST_GAP;
                        cnt_q[i]   <= gap_load;
                        ext_q[i]   <= IDLE_LVL;
                     end else begin
                        state_q[i] <= ST_IDLE;
                        ext_q[i]   <= IDLE_LVL;
                     end
                  end
               end
               ST_GAP: begin
                  // Edges during blanking, including its last cycle, are lost.
                  drop_q[i] <= rise[i];
                  ext_q[i]  <= IDLE_LVL;
                  if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                  else                state_q[i] <= ST_IDLE;
               end
               default: begin
                  state_q[i] <= ST_IDLE;
                  ext_q[i]   <= IDLE_LVL;
               end
            endcase
         end
      end
   end

   // Any channel outside IDLE keeps the block busy.
   // NOTE: combinational outputs get a default before any conditional update,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      busy_c = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (state_q[i] != ST_IDLE) busy_c = 1'b1;
      end
   end

   assign bus.ext_out = ext_q;
   assign bus.dropped = drop_q;
   assign bus.busy    = busy_c;

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Scoreboard bench for pulse_stretch_mc. Two instances: active-high outputs
// (main scenarios) and active-low outputs. Expected output words
// {busy, dropped, ext_out} are queued per cycle as each scenario is driven
// and compared on the falling edge of that cycle.
module tb_pulse_stretch_mc;

   typedef struct {
      int          cyc;
      logic [8:0]  exp;
      string       tag;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   base;
   int   n_checks;
   int   n_pass;
   exp_t sb_main [$];
   exp_t sb_neg  [$];

   pulse_stretch_mc_if #(.CHANNELS(4), .CNT_W(16)) bm ();
   pulse_stretch_mc_if #(.CHANNELS(4), .CNT_W(16)) bn ();

   pulse_stretch_mc #(
      .CHANNELS(4), .CNT_W(16), .NEGATIVE_OUT(1'b0), .SYNC_STAGES(0)
   ) dut (
      .clk(clk), .rst(rst), .bus(bm)
   );

   pulse_stretch_mc #(
      .CHANNELS(4), .CNT_W(16), .NEGATIVE_OUT(1'b1), .SYNC_STAGES(0)
   ) dut_n (
      .clk(clk), .rst(rst), .bus(bn)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s cyc=%0d got=%b expected=%b", tag, cyc, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [8:0] pk(input logic b, input logic [3:0] d, input logic [3:0] e);
      return {b, d, e};
   endfunction

   // Queue one expected word for cycles base+t0 .. base+t1 of one instance.
   task automatic exp_range(input bit neg, input string tag, input int t0, input int t1,
                            input logic [8:0] word);
      exp_t e;
      for (int t = t0; t <= t1; t++) begin
         e.cyc = base + t;
         e.exp = word;
         e.tag = tag;
         if (neg) sb_neg.push_back(e);
         else     sb_main.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare DUT outputs against every expectation due in this cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb_main.size() > 0 && sb_main[0].cyc <= cyc) begin
         e = sb_main.pop_front();
         check(e.tag, {bm.busy, bm.dropped, bm.ext_out}, e.exp);
      end
      while (sb_neg.size() > 0 && sb_neg[0].cyc <= cyc) begin
         e = sb_neg.pop_front();
         check(e.tag, {bn.busy, bn.dropped, bn.ext_out}, e.exp);
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
      $fatal(1, "simulation time limit");
   end

   initial begin : stimulus
      n_checks = 0;
      n_pass   = 0;
      base     = 0;
      rst      = 1'b1;
      bm.pulse_in = '0; bm.ext_len = 16'd5; bm.gap_len = '0; bm.retrig = 1'b0;
      bn.pulse_in = 4'hF; bn.ext_len = 16'd3; bn.gap_len = '0; bn.retrig = 1'b0;

      // Reset values, and an input held high through reset release.
      exp_range(1'b0, "rst_main", 1, 3, 9'h000);
      exp_range(1'b1, "rst_neg", 1, 3, pk(1'b0, 4'h0, 4'hF));
      exp_range(1'b1, "hold_release", 4, 12, pk(1'b0, 4'h0, 4'hF));
      repeat (3) tick();
      rst = 1'b0;
      repeat (6) tick();
      bn.pulse_in = '0;

      // ext_len=5 one-shot; ext_len change mid-pulse must not matter.
      base = cyc;
      exp_range(1'b0, "len5_pre", 0, 0, 9'h000);
      exp_range(1'b0, "len5_on", 1, 5, pk(1'b1, 4'h0, 4'h1));
      exp_range(1'b0, "len5_post", 6, 8, 9'h000);
      bm.pulse_in = 4'h1; tick();
      bm.pulse_in = 4'h0; tick();
      bm.ext_len = 16'd2;
      repeat (8) tick();

      // ext_len=0 gives one cycle; active-low instance triggered alongside.
      base = cyc;
      bm.ext_len = 16'd0;
      exp_range(1'b0, "len0_pre", 0, 0, 9'h000);
      exp_range(1'b0, "len0_on", 1, 1, pk(1'b1, 4'h0, 4'h2));
      exp_range(1'b0, "len0_post", 2, 4, 9'h000);
      exp_range(1'b1, "neg_pre", 0, 0, pk(1'b0, 4'h0, 4'hF));
      exp_range(1'b1, "neg_on", 1, 3, pk(1'b1, 4'h0, 4'hE));
      exp_range(1'b1, "neg_post", 4, 4, pk(1'b0, 4'h0, 4'hF));
      bm.pulse_in = 4'h2; bn.pulse_in = 4'h1; tick();
      bm.pulse_in = 4'h0; bn.pulse_in = 4'h0;
      repeat (5) tick();

      // ext_len=10, second edge at output cycle 6, retrig=1: 16 cycles total.
      base = cyc;
      bm.ext_len = 16'd10; bm.retrig = 1'b1;
      exp_range(1'b0, "retrig_pre", 0, 0, 9'h000);
      exp_range(1'b0, "retrig_on", 1, 16, pk(1'b1, 4'h0, 4'h1));
      exp_range(1'b0, "retrig_post", 17, 19, 9'h000);
      bm.pulse_in = 4'h1; tick();
      bm.pulse_in = 4'h0; repeat (5) tick();
      bm.pulse_in = 4'h1; tick();
      bm.pulse_in = 4'h0; repeat (13) tick();

      // Same with retrig=0: 10 cycles and one dropped strobe.
      base = cyc;
      bm.retrig = 1'b0;
      exp_range(1'b0, "noretrig_pre", 0, 0, 9'h000);
      exp_range(1'b0, "noretrig_on", 1, 6, pk(1'b1, 4'h0, 4'h1));
      exp_range(1'b0, "noretrig_drop", 7, 7, pk(1'b1, 4'h1, 4'h1));
      exp_range(1'b0, "noretrig_tail", 8, 10, pk(1'b1, 4'h0, 4'h1));
      exp_range(1'b0, "noretrig_post", 11, 13, 9'h000);
      bm.pulse_in = 4'h1; tick();
      bm.pulse_in = 4'h0; repeat (5) tick();
      bm.pulse_in = 4'h1; tick();
      bm.pulse_in = 4'h0; repeat (13) tick();

      // ext_len=4, gap_len=3, edges at t=0,5,8 on channel 2.
      base = cyc;
      bm.ext_len = 16'd4; bm.gap_len = 16'd3;
      exp_range(1'b0, "gap_pre", 0, 0, 9'h000);
      exp_range(1'b0, "gap_on1", 1, 4, pk(1'b1, 4'h0, 4'h4));
      exp_range(1'b0, "gap_blank", 5, 5, pk(1'b1, 4'h0, 4'h0));
      exp_range(1'b0, "gap_drop", 6, 6, pk(1'b1, 4'h4, 4'h0));
      exp_range(1'b0, "gap_last", 7, 7, pk(1'b1, 4'h0, 4'h0));
      exp_range(1'b0, "gap_idle", 8, 8, 9'h000);
      exp_range(1'b0, "gap_on2", 9, 12, pk(1'b1, 4'h0, 4'h4));
      exp_range(1'b0, "gap_blank2", 13, 15, pk(1'b1, 4'h0, 4'h0));
      exp_range(1'b0, "gap_post", 16, 17, 9'h000);
      for (int t = 0; t < 18; t++) begin
         bm.pulse_in = (t == 0 || t == 5 || t == 8) ? 4'h4 : 4'h0;
         tick();
      end

      // gap_len=0, edge on the last ON cycle is dropped; next edge accepted.
      base = cyc;
      bm.ext_len = 16'd3; bm.gap_len = 16'd0;
      exp_range(1'b0, "b2b_pre", 0, 0, 9'h000);
      exp_range(1'b0, "b2b_on1", 1, 3, pk(1'b1, 4'h0, 4'h8));
      exp_range(1'b0, "b2b_drop", 4, 4, pk(1'b0, 4'h8, 4'h0));
      exp_range(1'b0, "b2b_idle", 5, 5, 9'h000);
      exp_range(1'b0, "b2b_on2", 6, 8, pk(1'b1, 4'h0, 4'h8));
      exp_range(1'b0, "b2b_post", 9, 10, 9'h000);
      for (int t = 0; t < 11; t++) begin
         bm.pulse_in = (t == 0 || t == 3 || t == 5) ? 4'h8 : 4'h0;
         tick();
      end

      // Retrigger on the last ON cycle reloads instead of ending the pulse.
      base = cyc;
      bm.retrig = 1'b1;
      exp_range(1'b0, "lastre_pre", 0, 0, 9'h000);
      exp_range(1'b0, "lastre_on", 1, 6, pk(1'b1, 4'h0, 4'h1));
      exp_range(1'b0, "lastre_post", 7, 8, 9'h000);
      for (int t = 0; t < 10; t++) begin
         bm.pulse_in = (t == 0 || t == 3) ? 4'h1 : 4'h0;
         tick();
      end

      // All channels at once, reset at ON cycle 3, then a fresh full pulse.
      base = cyc;
      bm.retrig = 1'b0; bm.ext_len = 16'd8;
      exp_range(1'b0, "all_pre", 0, 0, 9'h000);
      exp_range(1'b0, "all_on", 1, 3, pk(1'b1, 4'h0, 4'hF));
      exp_range(1'b0, "all_rst", 4, 7, 9'h000);
      exp_range(1'b0, "fresh_on", 8, 15, pk(1'b1, 4'h0, 4'h1));
      exp_range(1'b0, "fresh_post", 16, 17, 9'h000);
      for (int t = 0; t < 18; t++) begin
         bm.pulse_in = (t == 0) ? 4'hF : ((t == 7) ? 4'h1 : 4'h0);
         rst = (t == 3);
         tick();
      end

      // Maximum length: 65535 cycles with no counter wrap.
      base = cyc;
      bm.ext_len = 16'hFFFF;
      exp_range(1'b0, "max_pre", 0, 0, 9'h000);
      exp_range(1'b0, "max_on", 1, 65535, pk(1'b1, 4'h0, 4'h2));
      exp_range(1'b0, "max_post", 65536, 65537, 9'h000);
      bm.pulse_in = 4'h2; tick();
      bm.pulse_in = 4'h0;
      repeat (65538) tick();

      for (int k = 0; k < 10 && (sb_main.size() + sb_neg.size()) > 0; k++) tick();
      check("sb_drain", 9'(sb_main.size() + sb_neg.size()), 9'h000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
